// File: rtl/msg_encode_gearbox.sv
// rtl/msg_encode_gearbox.sv - bit-level gearbox slicing a message stream into d-bit symbols, LANES per beat
// Optional MSG_ENCODE_ROUND_EN: set the half-step rounding bit below each symbol.
module msg_encode_gearbox #(
    parameter int IN_W   = 64,
    parameter int LANES  = 4,
    parameter int LANE_W = 16,
    parameter int MAX_D  = 4,
    parameter int N_COEF = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                d_sel,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err
);
    localparam int ACC_W     = 2 * IN_W;
    localparam int CNT_W     = $clog2(ACC_W + 1);
    localparam int OUT_BEATS = N_COEF / LANES;
    localparam int OB_W      = $clog2(OUT_BEATS + 1);
    localparam int IB_MAX    = (N_COEF / IN_W) * MAX_D;
    localparam int IB_W      = $clog2(IB_MAX + 1);
    localparam int BPD       = N_COEF / IN_W;
    localparam int SH_W      = $clog2(LANE_W + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        d_q, d_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IB_W-1:0]   in_left_q, in_left_d;
    logic [OB_W-1:0]   out_cnt_q, out_cnt_d;
    logic              err_q, err_d;

    logic              run, push, pop, d_legal;
    logic [CNT_W-1:0]  k, cnt_base;
    logic [ACC_W-1:0]  acc_shift;
    logic [SH_W-1:0]   sh;
    logic [MAX_D-1:0]  sym, sym_mask;
    logic [LANE_W-1:0] lane;

    always_comb begin
        run       = (state_q == S_RUN);
        k         = CNT_W'(LANES) * CNT_W'(d_q);
        in_ready  = run && (in_left_q != '0) && (cnt_q <= CNT_W'(IN_W));
        out_valid = run && (cnt_q >= k);
        out_last  = out_valid && (out_cnt_q == OB_W'(OUT_BEATS - 1));
        busy      = run;
        err       = err_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        d_legal   = (d_sel != 3'd0) && (d_sel <= 3'(MAX_D));

        acc_shift = pop ? (acc_q >> k) : acc_q;
        cnt_base  = pop ? (cnt_q - k) : cnt_q;

        state_d   = state_q;
        d_d       = d_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_left_d = in_left_q;
        out_cnt_d = out_cnt_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (d_legal) begin
                        state_d   = S_RUN;
                        d_d       = d_sel;
                        acc_d     = '0;
                        cnt_d     = '0;
                        in_left_d = IB_W'(BPD) * IB_W'(d_sel);
                        out_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Pop first, then append the new beat just above the surviving bits.
                acc_d = acc_shift;
                cnt_d = cnt_base;
                if (push) begin
                    acc_d     = acc_shift | ({{IN_W{1'b0}}, in_data} << cnt_base);
                    cnt_d     = cnt_base + CNT_W'(IN_W);
                    in_left_d = in_left_q - IB_W'(1);
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + OB_W'(1);
                    if (out_last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        sym      = '0;
        lane     = '0;
        sh       = SH_W'(LANE_W) - SH_W'(d_q);
        sym_mask = MAX_D'((32'd1 << d_q) - 32'd1);
        for (int i = 0; i < LANES; i++) begin
            sym  = MAX_D'(acc_q >> (i * int'(d_q))) & sym_mask;
            lane = LANE_W'(sym) << sh;
`ifdef MSG_ENCODE_ROUND_EN
            lane = lane | (LANE_W'(1) << (sh - SH_W'(1)));
`endif
            if (out_valid) out_data[i*LANE_W +: LANE_W] = lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            d_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            in_left_q <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            in_left_q <= in_left_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end
endmodule
